// File: rtl/shift_chain_sequencer.sv
// shift_chain_sequencer: shifts a WORDS x WIDTH serial chain per command, then drains it word by word
module shift_chain_sequencer #(
  parameter int WORDS = 5,
  parameter int WIDTH = 11,
  parameter int CW = $clog2(WORDS*WIDTH+1),
  parameter int IW = $clog2(WORDS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CW-1:0]    cmd_count,
  input  logic             cmd_mode,
  input  logic             cmd_clear,
  input  logic             serial_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_index,
  output logic [WIDTH-1:0] out_word,
  output logic             busy,
  output logic             done
);
  localparam int N = WORDS*WIDTH;
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;
  state_t state, state_nx;
  logic [N-1:0] chain;
  logic [CW-1:0] remaining, count_cl;
  logic [IW-1:0] index;
  logic mode, accept, last_word;
  assign accept = cmd_valid && cmd_ready;
  assign last_word = index == IW'(WORDS-1);
  assign count_cl = (cmd_count > CW'(N)) ? CW'(N) : cmd_count;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && accept) state_nx = (count_cl == '0) ? DRAIN : SHIFT;
    else if (state == SHIFT && remaining <= CW'(1)) state_nx = DRAIN;
    else if (state == DRAIN && out_ready && last_word) state_nx = IDLE;
  end
  // flat chain: bit k is word k/WIDTH, bit k%WIDTH, so one left shift ripples every word
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      chain <= '0;
      remaining <= '0;
      mode <= 1'b0;
      index <= '0;
      done <= 1'b0;
    end else begin
      if (accept) begin
        remaining <= count_cl;
        mode <= cmd_mode;
      end else if (state == SHIFT && remaining != '0) remaining <= remaining - 1'b1;
      if (accept && cmd_clear) chain <= '0;
      else if (state == SHIFT) chain <= {chain[N-2:0], mode ? ~chain[0] : serial_in};
      if (state == DRAIN && out_ready) index <= last_word ? '0 : index + 1'b1;
      done <= state == DRAIN && out_ready && last_word;
    end
  always_comb begin
    cmd_ready = state == IDLE;
    out_valid = state == DRAIN;
    busy = state != IDLE;
    out_index = index;
    out_word = out_valid ? chain[index*WIDTH +: WIDTH] : '0;
  end
endmodule

// File: tb/tb_shift_chain_sequencer.sv
// tb_shift_chain_sequencer: vector table plus scoreboard of expected drained words
module tb_shift_chain_sequencer;
  logic clock = 1'b0, reset_n;
  logic cmd_valid, cmd_ready, cmd_mode, cmd_clear, serial_in;
  logic [5:0] cmd_count;
  logic out_valid, out_ready, busy, done;
  logic [2:0] out_index;
  logic [10:0] out_word;
  int total = 0, bad = 0;
  typedef struct {
    int count;
    bit mode;
    bit clear;
    int ser;
    logic [4:0][10:0] exp;
    int hold;
    bit poke;
  } vec_t;
  typedef struct {
    logic [2:0] idx;
    logic [10:0] word;
  } exp_t;
  exp_t sb[$];
  vec_t vt[6];
  shift_chain_sequencer dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .cmd_mode(cmd_mode), .cmd_clear(cmd_clear), .serial_in(serial_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_word(out_word),
    .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drain(input int hold, input bit poke);
    exp_t e;
    logic [10:0] w;
    int n;
    out_ready = 1'b1;
    while (sb.size() != 0) begin
      n = 0;
      while (!out_valid && n < 20) begin
        step();
        n++;
      end
      if (!out_valid) begin
        chk("out_valid_timeout", 0, 1);
        sb.delete();
        break;
      end
      e = sb.pop_front();
      chk("out_index", 32'(out_index), 32'(e.idx));
      chk("out_word", 32'(out_word), 32'(e.word));
      chk("cmd_ready_drain", 32'(cmd_ready), 0);
      if (poke) begin
        cmd_valid = out_index != 3'd4;
        cmd_count = 6'd5;
        cmd_clear = 1'b1;
      end
      if (int'(out_index) == hold) begin
        out_ready = 1'b0;
        w = out_word;
        repeat (4) begin
          step();
          chk("hold_index", 32'(out_index), 32'(hold));
          chk("hold_word", 32'(out_word), 32'(w));
          chk("hold_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
      end
      step();
    end
    cmd_valid = 1'b0;
    chk("done_pulse", 32'(done), 1);
    chk("busy_after", 32'(busy), 0);
    step();
    chk("done_clear", 32'(done), 0);
  endtask
  task automatic run(input vec_t v);
    int cyc, lat;
    cmd_count = 6'(v.count);
    cmd_mode = v.mode;
    cmd_clear = v.clear;
    serial_in = v.ser != 0;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    for (int i = 0; i < 5; i++) sb.push_back('{3'(i), v.exp[i]});
    step();
    cmd_valid = 1'b0;
    chk("busy_run", 32'(busy), 1);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      step();
      cyc++;
      if (v.ser == 1) serial_in = 1'b0;
    end
    lat = (v.count > 55 ? 55 : v.count) + 1;
    chk("latency", 32'(cyc), 32'(lat));
    drain(v.hold, v.poke);
  endtask
  initial begin
    vt[0] = '{3, 1'b1, 1'b1, 0, {11'h0, 11'h0, 11'h0, 11'h0, 11'h5}, -1, 1'b0};
    vt[1] = '{12, 1'b0, 1'b1, 1, {11'h0, 11'h0, 11'h0, 11'h1, 11'h0}, -1, 1'b0};
    vt[2] = '{63, 1'b0, 1'b1, 2, {11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF}, -1, 1'b0};
    vt[3] = '{0, 1'b0, 1'b0, 0, {11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF}, 2, 1'b1};
    vt[4] = '{11, 1'b0, 1'b1, 2, {11'h0, 11'h0, 11'h0, 11'h0, 11'h7FF}, -1, 1'b0};
    vt[5] = '{2, 1'b1, 1'b0, 0, {11'h0, 11'h0, 11'h0, 11'h3, 11'h7FD}, -1, 1'b0};
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_count = '0;
    cmd_mode = 1'b0;
    cmd_clear = 1'b0;
    serial_in = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out_index", 32'(out_index), 0);
    chk("rst_out_word", 32'(out_word), 0);
    reset_n = 1'b1;
    step();
    for (int k = 0; k < 6; k++) run(vt[k]);
    cmd_count = 6'd55;
    cmd_mode = 1'b0;
    cmd_clear = 1'b1;
    serial_in = 1'b1;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (19) step();
    chk("mid_shift_busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cmd_ready", 32'(cmd_ready), 1);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_word", 32'(out_word), 0);
    #2 reset_n = 1'b1;
    serial_in = 1'b0;
    repeat (3) begin
      step();
      chk("arst_no_done", 32'(done), 0);
      chk("arst_idle", 32'(cmd_ready), 1);
    end
    run('{0, 1'b0, 1'b0, 0, '0, -1, 1'b0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
